// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM state codes,
// parity mode constants and the expected-parity helper.
package uart_pkg;

    typedef logic [2:0] uart_rx_state_t;

    localparam uart_rx_state_t ST_IDLE   = 3'd0;
    localparam uart_rx_state_t ST_START  = 3'd1;
    localparam uart_rx_state_t ST_DATA   = 3'd2;
    localparam uart_rx_state_t ST_PARITY = 3'd3;
    localparam uart_rx_state_t ST_STOP   = 3'd4;

    localparam int UART_PAR_NONE = 0;
    localparam int UART_PAR_ODD  = 1;
    localparam int UART_PAR_EVEN = 2;

    localparam int UART_MAX_DATA_BITS = 9;

    // Parity bit a sender must append so the frame meets the given mode.
    // Unused upper data bits must be zero.
    function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                         input int mode);
        logic ones;
        logic result;
        ones   = ^data;
        result = 1'b0;
        if (mode == UART_PAR_ODD) begin
            result = ~ones;
        end else if (mode == UART_PAR_EVEN) begin
            result = ones;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Front end of the receiver: 2-FF synchronizer, falling-edge detect,
// per-bit phase counter and a 3-point majority vote around the bit centre.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rxd,
    input  logic i_start,
    input  logic i_run,
    output logic o_rxd_fell,
    output logic o_line_high,
    output logic o_bit_val,
    output logic o_bit_rdy,
    output logic o_bit_end
);

    localparam int MID = CLK_PER_BIT / 2;
    localparam int CW  = $clog2(CLK_PER_BIT);

    localparam logic [CW-1:0] C_VOTE_A = CW'(MID - 1);
    localparam logic [CW-1:0] C_VOTE_B = CW'(MID);
    localparam logic [CW-1:0] C_VOTE_C = CW'(MID + 1);
    localparam logic [CW-1:0] C_LAST   = CW'(CLK_PER_BIT - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [1:0]    r_warm;
    logic [CW-1:0] r_bit_cnt;
    logic          r_vote_a;
    logic          r_vote_b;

    // Synchronize the pin, keep one older sample for edge detection, and
    // track when the synchronizer holds real line samples again after reset
    // (its forced-high reset value must not look like an idle line).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_warm  <= 2'b00;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_warm  <= {r_warm[0], 1'b1};
        end
    end

    // Bit phase counter. The cycle in which the start edge is seen counts as
    // phase 0, so the counter is loaded with 1 on the following clock.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt <= '0;
        end else if (i_start) begin
            r_bit_cnt <= CW'(1);
        end else if (i_run) begin
            r_bit_cnt <= (r_bit_cnt == C_LAST) ? '0 : r_bit_cnt + CW'(1);
        end else begin
            r_bit_cnt <= '0;
        end
    end

    // Capture the two early vote samples; the third is the live sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vote_a <= 1'b1;
            r_vote_b <= 1'b1;
        end else if (i_run) begin
            if (r_bit_cnt == C_VOTE_A) r_vote_a <= r_sync2;
            if (r_bit_cnt == C_VOTE_B) r_vote_b <= r_sync2;
        end
    end

    assign o_rxd_fell  = r_prev & ~r_sync2;
    assign o_line_high = r_warm[1] & r_sync2;
    assign o_bit_val   = (r_vote_a & r_vote_b) | (r_vote_a & r_sync2) | (r_vote_b & r_sync2);
    assign o_bit_rdy   = i_run && (r_bit_cnt == C_VOTE_C);
    assign o_bit_end   = i_run && (r_bit_cnt == C_LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: frame FSM, data shift register, parity and
// stop checks, and the registered output word with error pulses.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rxd,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_rx_frame_err,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_busy
);

    localparam int P        = (PARITY != UART_PAR_NONE) ? 1 : 0;
    localparam int LAST_IDX = DATA_BITS + P + STOP_BITS;

    uart_rx_state_t       r_state;
    logic                 r_armed;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_parity_err;

    logic w_rxd_fell;
    logic w_line_high;
    logic w_bit_val;
    logic w_bit_rdy;
    logic w_bit_end;
    logic w_start;
    logic w_run;
    logic w_stop_bad;

    assign w_run      = (r_state != ST_IDLE);
    assign w_start    = (r_state == ST_IDLE) && r_armed && w_rxd_fell;
    assign w_stop_bad = r_frame_err | ~w_bit_val;

    uart_bit_sampler #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_sampler (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rxd      (i_rxd),
        .i_start    (w_start),
        .i_run      (w_run),
        .o_rxd_fell (w_rxd_fell),
        .o_line_high(w_line_high),
        .o_bit_val  (w_bit_val),
        .o_bit_rdy  (w_bit_rdy),
        .o_bit_end  (w_bit_end)
    );

    // Frame FSM: decisions are taken at each vote resolution; the bit index
    // advances at each bit end. The frame completes at the last stop vote
    // without waiting for the bit end, so a slow sender is tolerated.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_armed         <= 1'b0;
            r_bit_idx       <= '0;
            r_shift         <= '0;
            r_frame_err     <= 1'b0;
            r_parity_err    <= 1'b0;
            o_rx_data       <= '0;
            o_rx_valid      <= 1'b0;
            o_rx_frame_err  <= 1'b0;
            o_rx_parity_err <= 1'b0;
            o_rx_busy       <= 1'b0;
        end else begin
            o_rx_valid      <= 1'b0;
            o_rx_frame_err  <= 1'b0;
            o_rx_parity_err <= 1'b0;
            if (w_bit_end) begin
                r_bit_idx <= r_bit_idx + 4'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_line_high) begin
                        r_armed <= 1'b1;
                    end
                    if (w_start) begin
                        r_state      <= ST_START;
                        r_bit_idx    <= '0;
                        r_frame_err  <= 1'b0;
                        r_parity_err <= 1'b0;
                        o_rx_busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_rdy) begin
                        if (w_bit_val) begin
                            r_state   <= ST_IDLE;
                            o_rx_busy <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_bit_rdy) begin
                        r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == 4'(DATA_BITS)) begin
                            r_state <= (P != 0) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_rdy) begin
                        r_parity_err <= (w_bit_val !=
                            uart_parity(UART_MAX_DATA_BITS'(r_shift), PARITY));
                        r_state      <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_bit_rdy) begin
                        if (r_bit_idx == 4'(LAST_IDX)) begin
                            r_state         <= ST_IDLE;
                            o_rx_busy       <= 1'b0;
                            o_rx_valid      <= 1'b1;
                            o_rx_data       <= r_shift;
                            o_rx_frame_err  <= w_stop_bad;
                            o_rx_parity_err <= r_parity_err;
                            if (w_stop_bad) begin
                                r_armed <= 1'b0;
                            end
                        end else begin
                            r_frame_err <= w_stop_bad;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    o_rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: one no-parity and one even-parity
// instance, each fed by a bit-accurate serial line model.
module tb_uart_rx_oversampled;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd0;
    logic       rxdP;
    logic [7:0] data0;
    logic [7:0] dataP;
    logic       valid0, ferr0, perr0, busy0;
    logic       validP, ferrP, perrP, busyP;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycleCnt    = 0;
    int frameStart  = 0;
    int lastValid0  = -1;
    int lastValidP  = -1;
    int lastFall0   = -1;
    logic busy0Prev = 1'b0;

    logic [9:0] rx0Q[$];
    logic [9:0] rxPQ[$];
    logic [7:0] exp5[100];

    uart_rx_oversampled #(
        .CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxd0),
        .o_rx_data(data0), .o_rx_valid(valid0), .o_rx_frame_err(ferr0),
        .o_rx_parity_err(perr0), .o_rx_busy(busy0)
    );

    uart_rx_oversampled #(
        .CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dutP (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxdP),
        .o_rx_data(dataP), .o_rx_valid(validP), .o_rx_frame_err(ferrP),
        .o_rx_parity_err(perrP), .o_rx_busy(busyP)
    );

    // Free-running clock and cycle counter used as the time base.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Record every output pulse and busy fall, sampled mid-cycle.
    always @(negedge clk) begin
        busy0Prev <= busy0;
        if (busy0Prev && !busy0) lastFall0 <= cycleCnt;
        if (valid0) begin
            rx0Q.push_back({ferr0, perr0, data0});
            lastValid0 <= cycleCnt;
        end
        if (validP) begin
            rxPQ.push_back({ferrP, perrP, dataP});
            lastValidP <= cycleCnt;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] buildFrame(input logic [7:0] d, input bit withPar,
                                               input logic parBit, input logic stopVal);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (withPar) begin
            f[9]  = parBit;
            f[10] = stopVal;
        end else begin
            f[9]  = stopVal;
        end
        return f;
    endfunction

    // Drive one frame; bit period is CPB*scale/1000 clocks (fractional
    // boundaries), with an optional 1-clk glitch at offset 1 of one bit.
    task automatic applyStimulus(input int sel, input logic [15:0] bits, input int nBits,
                                 input int scale, input int glitchBit);
        int   c;
        int   b;
        int   prevB;
        int   off;
        logic g;
        logic v;
        c     = 0;
        prevB = -1;
        off   = 0;
        while (1) begin
            b = (c * 1000) / (CPB * scale);
            if (b >= nBits) break;
            if (b != prevB) begin
                off   = 0;
                prevB = b;
            end else begin
                off++;
            end
            g = (b == glitchBit) && (off == 1);
            v = bits[b] ^ g;
            @(posedge clk);
            #1;
            if (sel == 0) rxd0 = v;
            else          rxdP = v;
            if (c == 0) frameStart = cycleCnt;
            c++;
        end
    endtask

    task automatic waitCycle(input int target);
        while (cycleCnt < target) @(negedge clk);
    endtask

    task automatic setLine0(input logic v);
        @(posedge clk);
        #1;
        rxd0 = v;
    endtask

    initial begin
        int n;
        int s;
        int got;
        logic [9:0] w;

        rst  = 1'b1;
        rxd0 = 1'b1;
        rxdP = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(valid0), 32'd0);
        checkOutput("reset_busy", 32'(busy0), 32'd0);
        checkOutput("reset_data", 32'(data0), 32'd0);
        checkOutput("reset_flags", 32'({ferr0, perr0}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Clean frame 0xA5 and its latency from the pin edge
        applyStimulus(0, buildFrame(8'hA5, 1'b0, 1'b0, 1'b1), 10, 1000, -1);
        s = frameStart;
        waitCycle(s + 165);
        checkOutput("a5_count", 32'(rx0Q.size()), 32'd1);
        w = (rx0Q.size() > 0) ? rx0Q.pop_front() : 10'h3FF;
        checkOutput("a5_word", 32'(w), 32'h0A5);
        checkOutput("a5_latency", 32'(lastValid0 - s), 32'd156);
        checkOutput("a5_busy_fall", 32'(lastFall0 - s), 32'd156);
        repeat (20) @(negedge clk);
        checkOutput("a5_data_held", 32'(data0), 32'hA5);

        // False start: low for 4 clocks only
        setLine0(1'b0);
        n = cycleCnt;
        repeat (4) @(posedge clk);
        #1;
        rxd0 = 1'b1;
        waitCycle(n + 40);
        checkOutput("false_start_no_pulse", 32'(rx0Q.size()), 32'd0);
        checkOutput("false_start_busy_fall", 32'(lastFall0 - n), 32'd12);
        applyStimulus(0, buildFrame(8'h3C, 1'b0, 1'b0, 1'b1), 10, 1000, -1);
        repeat (10) @(negedge clk);
        checkOutput("after_false_count", 32'(rx0Q.size()), 32'd1);
        w = (rx0Q.size() > 0) ? rx0Q.pop_front() : 10'h3FF;
        checkOutput("after_false_word", 32'(w), 32'h03C);

        // Frame error, then line stuck low for 5 bit times
        applyStimulus(0, buildFrame(8'h00, 1'b0, 1'b0, 1'b0), 10, 1000, -1);
        repeat (5 * CPB) @(negedge clk);
        checkOutput("ferr_count", 32'(rx0Q.size()), 32'd1);
        w = (rx0Q.size() > 0) ? rx0Q.pop_front() : 10'h000;
        checkOutput("ferr_word", 32'(w), 32'h200);
        setLine0(1'b1);
        repeat (30) @(negedge clk);
        checkOutput("ferr_no_retrigger", 32'(rx0Q.size()), 32'd0);
        applyStimulus(0, buildFrame(8'h5A, 1'b0, 1'b0, 1'b1), 10, 1000, -1);
        repeat (10) @(negedge clk);
        w = (rx0Q.size() > 0) ? rx0Q.pop_front() : 10'h3FF;
        checkOutput("ferr_recover_word", 32'(w), 32'h05A);

        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        applyStimulus(1, buildFrame(8'h07, 1'b1, 1'b0, 1'b1), 11, 1000, -1);
        s = frameStart;
        waitCycle(s + 185);
        checkOutput("par_bad_count", 32'(rxPQ.size()), 32'd1);
        w = (rxPQ.size() > 0) ? rxPQ.pop_front() : 10'h000;
        checkOutput("par_bad_word", 32'(w), 32'h107);
        checkOutput("par_latency", 32'(lastValidP - s), 32'd172);
        applyStimulus(1, buildFrame(8'h07, 1'b1, 1'b1, 1'b1), 11, 1000, -1);
        repeat (10) @(negedge clk);
        w = (rxPQ.size() > 0) ? rxPQ.pop_front() : 10'h3FF;
        checkOutput("par_good_word", 32'(w), 32'h007);
        applyStimulus(1, buildFrame(8'hFF, 1'b1, 1'b1, 1'b1), 11, 1000, -1);
        repeat (10) @(negedge clk);
        w = (rxPQ.size() > 0) ? rxPQ.pop_front() : 10'h000;
        checkOutput("par_ff_bad_word", 32'(w), 32'h1FF);

        // 100 back-to-back bytes, skewed bit time, glitches off-centre
        for (int i = 0; i < 100; i++) begin
            int scaleSel;
            exp5[i]  = 8'($urandom_range(0, 255));
            scaleSel = $urandom_range(0, 2);
            applyStimulus(0, buildFrame(exp5[i], 1'b0, 1'b0, 1'b1), 10,
                          (scaleSel == 0) ? 970 : ((scaleSel == 1) ? 1000 : 1030),
                          $urandom_range(0, 9));
        end
        repeat (40) @(negedge clk);
        checkOutput("stream_count", 32'(rx0Q.size()), 32'd100);
        got = rx0Q.size();
        for (int i = 0; i < 100 && i < got; i++) begin
            checkOutput($sformatf("stream_byte%0d", i), 32'(rx0Q[i]), 32'({2'b00, exp5[i]}));
        end
        rx0Q.delete();

        // Reset in the 4th data bit of 0xFF, line low at release
        for (int c = 0; c < 16 + 56; c++) begin
            setLine0((c < 16) ? 1'b0 : 1'b1);
        end
        @(posedge clk);
        #1;
        rst  = 1'b1;
        rxd0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_busy", 32'(busy0), 32'd0);
        checkOutput("rst_mid_data", 32'(data0), 32'd0);
        repeat (60) @(negedge clk);
        checkOutput("rst_mid_no_pulse", 32'(rx0Q.size()), 32'd0);
        checkOutput("rst_low_busy", 32'(busy0), 32'd0);
        setLine0(1'b1);
        repeat (20) @(negedge clk);
        applyStimulus(0, buildFrame(8'h81, 1'b0, 1'b0, 1'b1), 10, 1000, -1);
        repeat (10) @(negedge clk);
        checkOutput("rst_recover_count", 32'(rx0Q.size()), 32'd1);
        w = (rx0Q.size() > 0) ? rx0Q.pop_front() : 10'h3FF;
        checkOutput("rst_recover_word", 32'(w), 32'h081);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
